// File: rtl/memory_access_pkg.sv
// -----------------------------------------------------------------------------
// memory_access_pkg
// Shared definitions for the memory stage of the five-stage pipeline:
//   - FSM state encoding (IDLE / WAIT)
//   - one-hot branch-type constants, packed as {bgt, bne, beq}
//   - NOP_RD, the register index that suppresses write-back
//   - default cycle budget for an outstanding data-memory access
// -----------------------------------------------------------------------------
package memory_access_pkg;

    // FSM state encoding
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    // Branch-type bits, packed as {DX_bgt, DX_bne, DX_beq}
    localparam logic [2:0] BR_BEQ = 3'b001;
    localparam logic [2:0] BR_BNE = 3'b010;
    localparam logic [2:0] BR_BGT = 3'b100;

    // Destination register 0 means "no write-back"
    localparam logic [4:0] NOP_RD = 5'd0;

    // Cycles spent in WAIT without an ack before the access is aborted
    localparam int TIMEOUT_DEFAULT = 16;

endpackage

// File: rtl/memory_access_branch_resolve.sv
// -----------------------------------------------------------------------------
// branch_resolve
// Purely combinational branch resolution. The caller registers the results.
// Ports:
//   zero_i, sign_i   ALU flags
//   br_type_i [2:0]  {bgt, bne, beq}
//   pc_i     [31:0]  PC+4 of the branch
//   offset_i [31:0]  sign-extended word offset
//   taken_o          branch condition is satisfied
//   target_o [31:0]  pc_i + (offset_i << 2), wrapping mod 2^32
// -----------------------------------------------------------------------------
module branch_resolve
    import memory_access_pkg::*;
(
    input  logic        zero_i,
    input  logic        sign_i,
    input  logic [2:0]  br_type_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] offset_i,
    output logic        taken_o,
    output logic [31:0] target_o
);

    logic beq_hit;
    logic bne_hit;
    logic bgt_hit;

    assign beq_hit = ((br_type_i & BR_BEQ) != 3'b000) &&  zero_i;
    assign bne_hit = ((br_type_i & BR_BNE) != 3'b000) && !zero_i;
    assign bgt_hit = ((br_type_i & BR_BGT) != 3'b000) &&  sign_i;

    assign taken_o  = beq_hit | bne_hit | bgt_hit;

    // The word offset becomes a byte offset; the top two bits of the offset
    // fall off, matching the modulo-2^32 add.
    assign target_o = pc_i + {offset_i[29:0], 2'b00};

endmodule

// File: rtl/memory_access.sv
// -----------------------------------------------------------------------------
// memory_access
// Memory stage of the five-stage pipeline. It consumes the XM_* register from
// execute and drives the MW_* register read by write-back. Loads and stores go
// over a req/ack handshake; while an access is outstanding, ready is low and
// the upstream stages stall. Conditional branches are resolved here and
// produce a one-cycle redirect pulse.
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   ALUout, XM_RT, XM_RD            address/result, store data, dest reg
//   XM_MemToReg, XM_MemWrite        load / store select
//   zero, sign                      ALU flags for branch resolution
//   DX_beq, DX_bne, DX_bgt          branch type
//   DX_PC, DX_offset                PC+4 and word offset of the branch
//   ready                           combinational upstream enable
//   dmem_req/we/addr/wdata          registered data-memory request
//   dmem_rdata, dmem_ack            memory response (ack is a 1-cycle pulse)
//   MW_data, MW_RD                  write-back register
//   br_taken, br_target             redirect pulse and target
//   misalign, mem_err               one-cycle fault pulses
// -----------------------------------------------------------------------------
module memory_access
    import memory_access_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] ALUout,
    input  logic [31:0] XM_RT,
    input  logic [4:0]  XM_RD,
    input  logic        XM_MemToReg,
    input  logic        XM_MemWrite,
    input  logic        zero,
    input  logic        sign,
    input  logic        DX_beq,
    input  logic        DX_bne,
    input  logic        DX_bgt,
    input  logic [31:0] DX_PC,
    input  logic [31:0] DX_offset,
    output logic        ready,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic [31:0] MW_data,
    output logic [4:0]  MW_RD,
    output logic        br_taken,
    output logic [31:0] br_target,
    output logic        misalign,
    output logic        mem_err
);

    localparam int              CW       = $clog2(TIMEOUT);
    localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT - 1);

    // State registers
    logic [0:0]    state_q,     state_d;
    logic [CW-1:0] cnt_q,       cnt_d;
    logic [4:0]    rd_lat_q,    rd_lat_d;
    logic          load_lat_q,  load_lat_d;
    logic          req_q,       req_d;
    logic          we_q,        we_d;
    logic [31:0]   addr_q,      addr_d;
    logic [31:0]   wdata_q,     wdata_d;
    logic [31:0]   mw_data_q,   mw_data_d;
    logic [4:0]    mw_rd_q,     mw_rd_d;
    logic          br_taken_q,  br_taken_d;
    logic [31:0]   br_target_q, br_target_d;
    logic          misalign_q,  misalign_d;
    logic          mem_err_q,   mem_err_d;

    logic          mem_op;
    logic          aligned;
    logic          br_hit;
    logic [31:0]   br_tgt;

    assign mem_op  = XM_MemToReg | XM_MemWrite;
    assign aligned = (ALUout[1:0] == 2'b00);

    branch_resolve u_branch (
        .zero_i    (zero),
        .sign_i    (sign),
        .br_type_i ({DX_bgt, DX_bne, DX_beq}),
        .pc_i      (DX_PC),
        .offset_i  (DX_offset),
        .taken_o   (br_hit),
        .target_o  (br_tgt)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rd_lat_d    = rd_lat_q;
        load_lat_d  = load_lat_q;
        req_d       = req_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        mw_data_d   = mw_data_q;
        mw_rd_d     = mw_rd_q;
        br_target_d = br_target_q;
        // Pulse outputs default low so they never last more than one cycle
        br_taken_d  = 1'b0;
        misalign_d  = 1'b0;
        mem_err_d   = 1'b0;
        ready       = 1'b1;

        if (state_q == ST_IDLE) begin
            // A stray dmem_ack in IDLE is deliberately not looked at here.
            if (mem_op && aligned) begin
                ready      = 1'b0;
                req_d      = 1'b1;
                we_d       = XM_MemWrite;
                addr_d     = ALUout;
                wdata_d    = XM_RT;
                rd_lat_d   = XM_RD;
                load_lat_d = XM_MemToReg;
                mw_rd_d    = NOP_RD;
                cnt_d      = '0;
                state_d    = ST_WAIT;
            end else if (mem_op) begin
                // Misaligned access: drop the op, flag it, no request.
                mw_rd_d    = NOP_RD;
                misalign_d = 1'b1;
            end else begin
                mw_data_d   = ALUout;
                mw_rd_d     = XM_RD;
                br_taken_d  = br_hit;
                br_target_d = br_tgt;
            end
        end else begin
            // WAIT: bubble into write-back until the access resolves.
            ready   = 1'b0;
            mw_rd_d = NOP_RD;
            if (dmem_ack) begin
                // Ack takes priority over a coincident timeout.
                ready   = 1'b1;
                req_d   = 1'b0;
                state_d = ST_IDLE;
                if (load_lat_q) begin
                    mw_rd_d   = rd_lat_q;
                    mw_data_d = dmem_rdata;
                end
            end else if (cnt_q == CNT_LAST) begin
                ready     = 1'b1;
                req_d     = 1'b0;
                mem_err_d = 1'b1;
                state_d   = ST_IDLE;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            rd_lat_q    <= NOP_RD;
            load_lat_q  <= 1'b0;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            mw_data_q   <= '0;
            mw_rd_q     <= NOP_RD;
            br_taken_q  <= 1'b0;
            br_target_q <= '0;
            misalign_q  <= 1'b0;
            mem_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rd_lat_q    <= rd_lat_d;
            load_lat_q  <= load_lat_d;
            req_q       <= req_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            mw_data_q   <= mw_data_d;
            mw_rd_q     <= mw_rd_d;
            br_taken_q  <= br_taken_d;
            br_target_q <= br_target_d;
            misalign_q  <= misalign_d;
            mem_err_q   <= mem_err_d;
        end
    end

    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;
    assign MW_data    = mw_data_q;
    assign MW_RD      = mw_rd_q;
    assign br_taken   = br_taken_q;
    assign br_target  = br_target_q;
    assign misalign   = misalign_q;
    assign mem_err    = mem_err_q;

endmodule

// File: tb/tb_memory_access.sv
// -----------------------------------------------------------------------------
// tb_memory_access
// Directed bench for memory_access (TIMEOUT = 4). Inputs change 1 ns after a
// rising edge; outputs are sampled in the same window, well away from the
// next edge.
// -----------------------------------------------------------------------------
module tb_memory_access;

    logic        clk;
    logic        rst_n;
    logic [31:0] ALUout;
    logic [31:0] XM_RT;
    logic [4:0]  XM_RD;
    logic        XM_MemToReg;
    logic        XM_MemWrite;
    logic        zero;
    logic        sign;
    logic        DX_beq;
    logic        DX_bne;
    logic        DX_bgt;
    logic [31:0] DX_PC;
    logic [31:0] DX_offset;
    logic        ready;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;
    logic [31:0] MW_data;
    logic [4:0]  MW_RD;
    logic        br_taken;
    logic [31:0] br_target;
    logic        misalign;
    logic        mem_err;

    int cmp_cnt = 0;
    int err_cnt = 0;

    memory_access #(.TIMEOUT(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ALUout      (ALUout),
        .XM_RT       (XM_RT),
        .XM_RD       (XM_RD),
        .XM_MemToReg (XM_MemToReg),
        .XM_MemWrite (XM_MemWrite),
        .zero        (zero),
        .sign        (sign),
        .DX_beq      (DX_beq),
        .DX_bne      (DX_bne),
        .DX_bgt      (DX_bgt),
        .DX_PC       (DX_PC),
        .DX_offset   (DX_offset),
        .ready       (ready),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_wdata  (dmem_wdata),
        .dmem_rdata  (dmem_rdata),
        .dmem_ack    (dmem_ack),
        .MW_data     (MW_data),
        .MW_RD       (MW_RD),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .misalign    (misalign),
        .mem_err     (mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
        $display("check %-22s observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [31:0] alu, input logic [31:0] rt, input logic [4:0] rd,
                          input logic ld, input logic st);
        ALUout      = alu;
        XM_RT       = rt;
        XM_RD       = rd;
        XM_MemToReg = ld;
        XM_MemWrite = st;
    endtask

    task automatic set_br(input logic beq, input logic bne, input logic bgt,
                          input logic z, input logic s, input logic [31:0] pc, input logic [31:0] off);
        DX_beq    = beq;
        DX_bne    = bne;
        DX_bgt    = bgt;
        zero      = z;
        sign      = s;
        DX_PC     = pc;
        DX_offset = off;
    endtask

    initial begin
        rst_n      = 1'b0;
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
        set_op(32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
        set_br(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

        // ---- reset ----
        tick();
        tick();
        chk("rst_ready",    {31'h0, ready},    32'h1);
        chk("rst_req",      {31'h0, dmem_req}, 32'h0);
        chk("rst_MW_data",  MW_data,           32'h0);
        chk("rst_MW_RD",    {27'h0, MW_RD},    32'h0);
        chk("rst_br_taken", {31'h0, br_taken}, 32'h0);
        chk("rst_br_target", br_target,        32'h0);
        chk("rst_faults",   {30'h0, misalign, mem_err}, 32'h0);
        rst_n = 1'b1;

        // ---- ALU op ----
        set_op(32'h0000_0123, 32'h0, 5'd5, 1'b0, 1'b0);
        #1 chk("alu_ready", {31'h0, ready}, 32'h1);
        tick();
        chk("alu_MW_data", MW_data,        32'h0000_0123);
        chk("alu_MW_RD",   {27'h0, MW_RD}, 32'd5);

        // ---- load, ack on 3rd WAIT cycle ----
        set_op(32'h0000_0100, 32'h0, 5'd7, 1'b1, 1'b0);
        #1 chk("ld_ready_idle", {31'h0, ready}, 32'h0);
        tick();                                            // WAIT 1
        chk("ld_req",    {31'h0, dmem_req}, 32'h1);
        chk("ld_we",     {31'h0, dmem_we},  32'h0);
        chk("ld_addr",   dmem_addr,         32'h0000_0100);
        chk("ld_bubble", {27'h0, MW_RD},    32'h0);
        chk("ld_ready_w1", {31'h0, ready},  32'h0);
        tick();                                            // WAIT 2
        chk("ld_ready_w2", {31'h0, ready},  32'h0);
        tick();                                            // WAIT 3
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hDEAD_BEEF;
        #1 chk("ld_ready_ack", {31'h0, ready}, 32'h1);
        tick();
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
        chk("ld_MW_data", MW_data,           32'hDEAD_BEEF);
        chk("ld_MW_RD",   {27'h0, MW_RD},    32'd7);
        chk("ld_req_off", {31'h0, dmem_req}, 32'h0);

        // ---- store, ack on first WAIT cycle ----
        set_op(32'h0000_0204, 32'h0000_0055, 5'd9, 1'b0, 1'b1);
        tick();                                            // WAIT 1
        chk("st_req",   {31'h0, dmem_req}, 32'h1);
        chk("st_we",    {31'h0, dmem_we},  32'h1);
        chk("st_addr",  dmem_addr,         32'h0000_0204);
        chk("st_wdata", dmem_wdata,        32'h0000_0055);
        dmem_ack = 1'b1;
        #1 chk("st_ready_ack", {31'h0, ready}, 32'h1);
        tick();
        dmem_ack = 1'b0;
        chk("st_MW_RD",   {27'h0, MW_RD},    32'h0);
        chk("st_MW_data", MW_data,           32'hDEAD_BEEF);
        chk("st_req_off", {31'h0, dmem_req}, 32'h0);

        // ---- misaligned load (with a would-be-taken branch present) ----
        set_op(32'h0000_0102, 32'h0, 5'd3, 1'b1, 1'b0);
        set_br(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_1000, 32'h4);
        #1 chk("mis_ready", {31'h0, ready}, 32'h1);
        tick();
        chk("mis_pulse", {31'h0, misalign}, 32'h1);
        chk("mis_no_req", {31'h0, dmem_req}, 32'h0);
        chk("mis_MW_RD", {27'h0, MW_RD},    32'h0);
        chk("mis_no_br", {31'h0, br_taken}, 32'h0);
        set_br(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_op(32'h0000_0010, 32'h0, 5'd2, 1'b0, 1'b0);
        tick();
        chk("mis_pulse_end", {31'h0, misalign}, 32'h0);
        chk("mis_next_RD",   {27'h0, MW_RD},    32'd2);

        // ---- timeout (TIMEOUT = 4) ----
        set_op(32'h0000_0300, 32'h0, 5'd4, 1'b1, 1'b0);
        tick();                                            // WAIT 1
        chk("to_req", {31'h0, dmem_req}, 32'h1);
        tick();                                            // WAIT 2
        tick();                                            // WAIT 3
        chk("to_ready_w3", {31'h0, ready},   32'h0);
        chk("to_no_err_w3", {31'h0, mem_err}, 32'h0);
        tick();                                            // WAIT 4
        chk("to_ready_w4", {31'h0, ready},   32'h1);
        tick();
        chk("to_err",     {31'h0, mem_err},  32'h1);
        chk("to_req_off", {31'h0, dmem_req}, 32'h0);
        chk("to_MW_RD",   {27'h0, MW_RD},    32'h0);
        // stray ack in IDLE alongside an ALU op must be ignored
        set_op(32'h0000_0077, 32'h0, 5'd6, 1'b0, 1'b0);
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h1111_2222;
        #1 chk("idle_ack_ready", {31'h0, ready}, 32'h1);
        tick();
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
        chk("to_err_end",   {31'h0, mem_err}, 32'h0);
        chk("idle_ack_data", MW_data,         32'h0000_0077);
        chk("idle_ack_RD",  {27'h0, MW_RD},   32'd6);
        chk("idle_ack_req", {31'h0, dmem_req}, 32'h0);

        // ---- branches ----
        set_op(32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
        set_br(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0040, 32'hFFFF_FFFE);
        tick();
        chk("bne_taken",  {31'h0, br_taken}, 32'h1);
        chk("bne_target", br_target,         32'h0000_0038);
        set_br(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0040, 32'h0000_0010);
        tick();
        chk("beq_not_taken", {31'h0, br_taken}, 32'h0);
        set_br(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0100, 32'h0000_0003);
        tick();
        chk("bgt_taken",  {31'h0, br_taken}, 32'h1);
        chk("bgt_target", br_target,         32'h0000_010C);
        set_br(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        chk("br_pulse_end", {31'h0, br_taken}, 32'h0);

        // ---- ack coinciding with timeout: ack wins ----
        set_op(32'h0000_0500, 32'h0, 5'd11, 1'b1, 1'b0);
        tick();                                            // WAIT 1
        tick();                                            // WAIT 2
        tick();                                            // WAIT 3
        tick();                                            // WAIT 4 (last)
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h0000_CAFE;
        tick();
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
        chk("race_no_err", {31'h0, mem_err}, 32'h0);
        chk("race_data",   MW_data,          32'h0000_CAFE);
        chk("race_RD",     {27'h0, MW_RD},   32'd11);

        // ---- reset mid-WAIT, late ack ----
        set_op(32'h0000_0400, 32'h0, 5'd8, 1'b1, 1'b0);
        tick();                                            // WAIT 1
        chk("rw_req", {31'h0, dmem_req}, 32'h1);
        rst_n = 1'b0;
        tick();
        chk("rw_req_off", {31'h0, dmem_req}, 32'h0);
        chk("rw_addr",    dmem_addr,         32'h0);
        chk("rw_MW_data", MW_data,           32'h0);
        rst_n = 1'b1;
        set_op(32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h9999_8888;
        #1 chk("rw_ready", {31'h0, ready}, 32'h1);
        tick();
        dmem_ack   = 1'b0;
        chk("rw_late_data", MW_data,           32'h0);
        chk("rw_late_RD",   {27'h0, MW_RD},    32'h0);
        chk("rw_late_req",  {31'h0, dmem_req}, 32'h0);
        chk("rw_late_err",  {31'h0, mem_err},  32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
